// File: rtl/wb_target_mem.sv
// wb_target_mem: Wishbone classic target with word memory, byte lanes and wait states
module wb_target_mem #(
    parameter int          DEPTH_LOG2  = 8,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] adr,
    input  logic [31:0] dat_w,
    output logic [31:0] dat_r,
    input  logic [3:0]  sel,
    input  logic        we,
    input  logic        cyc,
    input  logic        stb,
    output logic        ack,
    output logic        err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [31:0]           r_mem [0:2**DEPTH_LOG2-1];
    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [31:0]           r_dat_w;
    logic [3:0]            r_sel;
    logic                  r_we;
    logic                  r_bad;
    logic                  r_ack;
    logic                  r_err;
    logic [31:0]           r_dat_r;
    logic                  w_req;
    logic                  w_bad;
    logic                  w_wr;

    // The IDLE cycle carrying a response pulse ignores the bus, forcing a turnaround gap.
    assign w_req = cyc && stb && !r_ack && !r_err;
    assign w_bad = (adr[1:0] != 2'b00) || (adr[31:DEPTH_LOG2+2] != BASE_ADDR[31:DEPTH_LOG2+2]);
    assign w_wr  = (r_state == RESP) && !reset && r_we && !r_bad;
    assign ack   = r_ack;
    assign err   = r_err;
    assign dat_r = r_dat_r;

    // Memory array is not reset; a write commits on the edge that raises ack.
    always_ff @(posedge clk) begin
        if (w_wr)
            for (int i = 0; i < 4; i++)
                if (r_sel[i]) r_mem[r_idx][8*i +: 8] <= r_dat_w[8*i +: 8];
    end

    // Request capture, wait-state countdown and single-cycle ack/err generation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat_r <= 32'd0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: if (w_req) begin
                    r_idx   <= adr[DEPTH_LOG2+1:2];
                    r_dat_w <= dat_w;
                    r_sel   <= sel;
                    r_we    <= we;
                    r_bad   <= w_bad;
                    if (WAIT_STATES == 0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt   <= 4'(WAIT_STATES - 1);
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    r_state <= !cyc ? IDLE : (r_cnt == 4'd0) ? RESP : WAIT;
                    r_cnt   <= r_cnt - 4'd1;
                end
                RESP: begin
                    r_state <= IDLE;
                    r_ack   <= !r_bad;
                    r_err   <= r_bad;
                    if (!r_bad && !r_we) r_dat_r <= r_mem[r_idx];
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
